// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity constants and bit-timing helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} tx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port between the byte FIFO and its UART transmitter
interface fifo_uart_tx_if;
  logic fifo_rd;
  logic fifo_empty;
  logic [7:0] fifo_dout;
  modport master (output fifo_rd, input fifo_empty, input fifo_dout);
  modport slave (input fifo_rd, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; tick marks the last clock of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO and serialises them as UART frames
// (start, 8 data LSB-first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int BAUD       = 100_000,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  if (CPB < 2) begin : g_cpb_chk
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end
  tx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] rdy_q, rdy_d;
  logic tx_q, tx_d, par_q, par_d, done_q, done_d, tick;
  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk(clk),
    .rst(rst),
    .restart(state_q == LOAD),
    .tick(tick)
  );
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign fifo.fifo_rd = (state_q == FETCH) && !fifo.fifo_empty;
  // idx_q counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    shift_d = shift_q;
    par_d = par_q;
    idx_d = idx_q;
    done_d = 1'b0;
    rdy_d = {rdy_q[0], 1'b1};
    unique case (state_q)
      IDLE: state_d = (rdy_q[1] && en && !fifo.fifo_empty) ? FETCH : IDLE;
      FETCH: state_d = fifo.fifo_empty ? IDLE : LOAD;
      LOAD: begin
        shift_d = fifo.fifo_dout;
        par_d = (^fifo.fifo_dout) ^ PAR_SEL;
        tx_d = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d = shift_q[0];
        shift_d = shift_q >> 1;
        idx_d = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        tx_d = (idx_q == 3'd7) ? ((PARITY_EN != 0) ? par_q : 1'b1) : shift_q[0];
        shift_d = shift_q >> 1;
        idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        state_d = (idx_q != 3'd7) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        tx_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (tick) begin
        done_d = idx_q == STOP_LAST;
        idx_d = (idx_q == STOP_LAST) ? 3'd0 : idx_q + 3'd1;
        state_d = (idx_q != STOP_LAST) ? STOP : (en && !fifo.fifo_empty) ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      shift_q <= '0;
      par_q <= 1'b0;
      idx_q <= '0;
      done_q <= 1'b0;
      rdy_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      shift_q <= shift_d;
      par_q <= par_d;
      idx_q <= idx_d;
      done_q <= done_d;
      rdy_q <= rdy_d;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of framing, FIFO handshake, parity, enable and reset behaviour
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0;
  logic en_p = 1'b0;
  logic p_empty = 1'b1;
  logic tx0, busy0, done0, tx1, busy1, done1, tx2, busy2, done2;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int rd_bad = 0;
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;
  always #5 clk = ~clk;
  fifo_uart_tx_if if0();
  fifo_uart_tx_if if1();
  fifo_uart_tx_if if2();
  fifo_uart_tx dut0 (.clk(clk), .rst(rst), .en(en0), .fifo(if0.master), .tx(tx0), .busy(busy0), .done(done0));
  fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .en(en_p), .fifo(if1.master), .tx(tx1), .busy(busy1), .done(done1));
  fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .en(en_p), .fifo(if2.master), .tx(tx2), .busy(busy2), .done(done2));
  assign if0.fifo_empty = wp == rp;
  assign if1.fifo_empty = p_empty;
  assign if2.fifo_empty = p_empty;
  assign if1.fifo_dout = 8'h07;
  assign if2.fifo_dout = 8'h07;
  always @(posedge clk) begin
    if (if0.fifo_rd) begin
      if0.fifo_dout <= mem[rp];
      rp <= rp + 4'd1;
    end
    if (if0.fifo_rd) rd_cnt++;
    if (if0.fifo_rd && if0.fifo_empty) rd_bad++;
    if (done0) done_cnt++;
  end
  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 4'd1;
  endtask
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (tx0 !== f[c/10]) begin
        errors++;
        $display("FAIL %s cycle %0d tx=%b expected %b", nm, c, tx0, f[c/10]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    en0 = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({tx0, if0.fifo_rd, busy0, done0} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_outputs tx/rd/busy/done=%b expected 1000", {tx0, if0.fifo_rd, busy0, done0});
      end
    end
    checks++;
    if (rp !== 4'd0) begin
      errors++;
      $display("FAIL reset_rp rp=%0d expected 0", rp);
    end
    en0 = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_single();
    int r0, d0;
    r0 = rd_cnt;
    d0 = done_cnt;
    en0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.fifo_rd, busy0, tx0} !== 3'b111) begin
      errors++;
      $display("FAIL single_fetch rd/busy/tx=%b expected 111", {if0.fifo_rd, busy0, tx0});
    end
    @(negedge clk);
    checks++;
    if ({if0.fifo_rd, tx0} !== 2'b01) begin
      errors++;
      $display("FAIL single_load rd/tx=%b expected 01", {if0.fifo_rd, tx0});
    end
    @(negedge clk);
    check_frame(8'hA5, "single_a5");
    checks++;
    if ({done0, busy0} !== 2'b10) begin
      errors++;
      $display("FAIL single_done done/busy=%b expected 10", {done0, busy0});
    end
    @(negedge clk);
    en0 = 1'b0;
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse done=%b expected 0", done0);
    end
    checks++;
    if (rd_cnt - r0 !== 1 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_counts rd=%0d done=%0d expected 1 1", rd_cnt - r0, done_cnt - d0);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int r0, d0;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    r0 = rd_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(bytes[i]);
    en0 = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_frame(bytes[k], "b2b_frame");
      if (k < 2) begin
        checks++;
        if ({done0, tx0, if0.fifo_rd} !== 3'b111) begin
          errors++;
          $display("FAIL b2b_gap1 done/tx/rd=%b expected 111", {done0, tx0, if0.fifo_rd});
        end
        @(negedge clk);
        checks++;
        if (tx0 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap2 tx=%b expected 1", tx0);
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({done0, busy0, if0.fifo_empty} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_end done/busy/empty=%b expected 101", {done0, busy0, if0.fifo_empty});
    end
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_cnt - r0 !== 3 || done_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL b2b_counts rd=%0d done=%0d expected 3 3", rd_cnt - r0, done_cnt - d0);
    end
  endtask
  task automatic test_parity();
    logic [11:0] f1;
    logic [10:0] f2;
    logic e1, e2;
    f1 = 12'b1110_0000_1110;
    f2 = 11'b100_0000_1110;
    p_empty = 1'b0;
    en_p = 1'b1;
    repeat (2) @(negedge clk);
    p_empty = 1'b1;
    en_p = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 122; c++) begin
      e1 = (c < 120) ? f1[c/10] : 1'b1;
      e2 = (c < 110) ? f2[c/10] : 1'b1;
      checks++;
      if ({tx1, tx2} !== {e1, e2}) begin
        errors++;
        $display("FAIL parity_tx cycle %0d tx_even2/tx_odd1=%b expected %b", c, {tx1, tx2}, {e1, e2});
      end
      checks++;
      if ({done1, done2} !== {c == 120, c == 110}) begin
        errors++;
        $display("FAIL parity_done cycle %0d done_even2/done_odd1=%b expected %b", c, {done1, done2}, {c == 120, c == 110});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy1, busy2} !== 2'b00) begin
      errors++;
      $display("FAIL parity_busy busy=%b expected 00", {busy1, busy2});
    end
  endtask
  task automatic test_en_drop();
    int n;
    push(8'h55);
    push(8'h66);
    push(8'h77);
    en0 = 1'b1;
    repeat (48) @(negedge clk);
    en0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_done done=%b expected 1 within 200 cycles", done0);
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      checks++;
      if ({if0.fifo_rd, tx0} !== 2'b01) begin
        errors++;
        $display("FAIL en_drop_idle rd/tx=%b expected 01", {if0.fifo_rd, tx0});
      end
    end
    checks++;
    if (wp - rp !== 4'd2) begin
      errors++;
      $display("FAIL en_drop_left fifo count=%0d expected 2", wp - rp);
    end
  endtask
  task automatic test_rst_mid();
    int n;
    en0 = 1'b1;
    repeat (68) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({tx0, busy0, done0} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid tx/busy/done=%b expected 100", {tx0, busy0, done0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart tx=%b expected start bit within 20 cycles", tx0);
    end
    en0 = 1'b0;
    check_frame(8'h77, "rst_next_byte");
    checks++;
    if ({done0, if0.fifo_empty, rd_bad != 0} !== 3'b110) begin
      errors++;
      $display("FAIL rst_end done/empty/rd_while_empty=%b expected 110", {done0, if0.fifo_empty, rd_bad != 0});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_en_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
